// File: rtl/int_issue_queue_pkg.sv
// Shared types and helpers for the integer issue queue.
// INT_ISSUE_AGE_SELECT_EN (see int_issue_queue_issue_select) switches port 0 to oldest-first select.
package int_issue_queue_pkg;
    localparam int DEPTH      = 16;
    localparam int DIS_PORT   = 4;
    localparam int ISSUE_PORT = 2;
    localparam int WB_PORT    = 4;
    localparam int DATA_WIDTH = 64;
    localparam int PREG_WIDTH = 7;
    localparam int ROB_WIDTH  = 6;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                 dir;
        logic [ROB_WIDTH-2:0] idx;
    } rob_idx_t;

    typedef struct packed {
        logic                  valid;
        logic [PREG_WIDTH-1:0] rs1;
        logic [PREG_WIDTH-1:0] rs2;
        logic                  rs1_rdy;
        logic                  rs2_rdy;
        rob_idx_t              rob_idx;
        logic [DATA_WIDTH-1:0] data;
    } issue_queue_entry_t;

    // 1 when a is strictly older than b; the dir bit flips each time the ROB wraps.
    function automatic logic rob_older(input rob_idx_t a, input rob_idx_t b);
        return (a.dir ^ b.dir) ^ (b.idx > a.idx);
    endfunction

    function automatic logic [DEPTH-1:0] lowest_one(input logic [DEPTH-1:0] v);
        return v & (~v + {{(DEPTH-1){1'b0}}, 1'b1});
    endfunction
endpackage

// File: rtl/int_issue_queue_issue_select.sv
// Issue select: one-hot grant per issue port from the ready vector, lowest index first.
// With INT_ISSUE_AGE_SELECT_EN defined, port 0 instead takes the oldest ready entry by robIdx.
module int_issue_queue_issue_select
    import int_issue_queue_pkg::*;
(
    input  logic [DEPTH-1:0]                  ready,
    input  logic [ISSUE_PORT-1:0]             stall,
`ifdef INT_ISSUE_AGE_SELECT_EN
    input  rob_idx_t                          entry_rob [DEPTH],
`endif
    output logic [ISSUE_PORT-1:0][DEPTH-1:0]  grant
);
    logic [DEPTH-1:0] first_pick;
    logic [DEPTH-1:0] avail;

`ifdef INT_ISSUE_AGE_SELECT_EN
    logic [DEPTH-1:0] oldest;

    // An entry is oldest when it is older than every other ready entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && !rob_older(entry_rob[i], entry_rob[j]))
                    oldest[i] = 1'b0;
            end
        end
    end

    assign first_pick = stall[0] ? '0 : oldest;
`else
    assign first_pick = stall[0] ? '0 : lowest_one(ready);
`endif

    // Stalled ports consume no candidate, so later ports still see the lowest free ones.
    always_comb begin
        grant    = '0;
        grant[0] = first_pick;
        avail    = ready & ~first_pick;
        for (int p = 1; p < ISSUE_PORT; p++) begin
            if (!stall[p])
                grant[p] = lowest_one(avail);
            avail = avail & ~grant[p];
        end
    end
endmodule

// File: rtl/int_issue_queue.sv
// Integer/branch issue queue: dispatch write with wakeup bypass, select, registered issue slots, redirect flush.
// Optional INT_ISSUE_AGE_SELECT_EN selects oldest-first on issue port 0.
module int_issue_queue
    import int_issue_queue_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DIS_PORT-1:0]                   dis_en,
    input  logic [DIS_PORT-1:0][PREG_WIDTH-1:0]   dis_rs1,
    input  logic [DIS_PORT-1:0][PREG_WIDTH-1:0]   dis_rs2,
    input  logic [DIS_PORT-1:0]                   dis_rs1v,
    input  logic [DIS_PORT-1:0]                   dis_rs2v,
    input  logic [DIS_PORT-1:0][ROB_WIDTH-1:0]    dis_robIdx,
    input  logic [DIS_PORT-1:0][DATA_WIDTH-1:0]   dis_data,
    output logic                                  full,
    input  logic [WB_PORT-1:0]                    wb_en,
    input  logic [WB_PORT-1:0][PREG_WIDTH-1:0]    wb_prd,
    input  logic                                  redirect,
    input  logic [ROB_WIDTH-1:0]                  redirect_idx,
    input  logic [ISSUE_PORT-1:0]                 issue_stall,
    output logic [ISSUE_PORT-1:0]                 issue_en,
    output logic [ISSUE_PORT-1:0][PREG_WIDTH-1:0] issue_rs1,
    output logic [ISSUE_PORT-1:0][PREG_WIDTH-1:0] issue_rs2,
    output logic [ISSUE_PORT-1:0][ROB_WIDTH-1:0]  issue_robIdx,
    output logic [ISSUE_PORT-1:0][DATA_WIDTH-1:0] issue_data
);
    // Handshakes: dispatch may present a group only while the registered full is 0;
    // issue slot p is taken by the FU every cycle issue_stall[p] = 0 and held while it is 1.
    issue_queue_entry_t                  q     [DEPTH];
    issue_queue_entry_t                  q_nxt [DEPTH];
    logic [DEPTH-1:0]                    ready;
    logic [ISSUE_PORT-1:0]               sel_stall;
    logic [ISSUE_PORT-1:0][DEPTH-1:0]    grant;
    logic [ISSUE_PORT-1:0][PREG_WIDTH-1:0] pick_rs1;
    logic [ISSUE_PORT-1:0][PREG_WIDTH-1:0] pick_rs2;
    logic [ISSUE_PORT-1:0][ROB_WIDTH-1:0]  pick_rob;
    logic [ISSUE_PORT-1:0][DATA_WIDTH-1:0] pick_data;
    logic [DEPTH-1:0]                    free;
    logic [DEPTH-1:0]                    slot;
    logic [CNT_W-1:0]                    cnt;
    logic                                accept;
    logic                                full_nxt;

    function automatic logic woken(input logic [PREG_WIDTH-1:0] preg,
                                   input logic [WB_PORT-1:0] en,
                                   input logic [WB_PORT-1:0][PREG_WIDTH-1:0] prd);
        logic hit;
        hit = (preg == '0);
        for (int k = 0; k < WB_PORT; k++)
            if (en[k] && prd[k] == preg) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ready[i] = q[i].valid & q[i].rs1_rdy & q[i].rs2_rdy;
    end

    assign sel_stall = issue_stall | {ISSUE_PORT{redirect}};

`ifdef INT_ISSUE_AGE_SELECT_EN
    rob_idx_t entry_rob [DEPTH];
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            entry_rob[i] = q[i].rob_idx;
    end
`endif

    int_issue_queue_issue_select u_select (
        .ready     (ready),
        .stall     (sel_stall),
`ifdef INT_ISSUE_AGE_SELECT_EN
        .entry_rob (entry_rob),
`endif
        .grant     (grant)
    );

    always_comb begin
        for (int p = 0; p < ISSUE_PORT; p++) begin
            pick_rs1[p]  = '0;
            pick_rs2[p]  = '0;
            pick_rob[p]  = '0;
            pick_data[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[p][i]) begin
                    pick_rs1[p]  = q[i].rs1;
                    pick_rs2[p]  = q[i].rs2;
                    pick_rob[p]  = q[i].rob_idx;
                    pick_data[p] = q[i].data;
                end
            end
        end
    end

    always_comb begin
        accept = !full && !redirect;
        free   = '0;
        slot   = '0;
        cnt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free[i]  = !q[i].valid;
            q_nxt[i] = q[i];
            if (q[i].valid) begin
                if (woken(q[i].rs1, wb_en, wb_prd)) q_nxt[i].rs1_rdy = 1'b1;
                if (woken(q[i].rs2, wb_en, wb_prd)) q_nxt[i].rs2_rdy = 1'b1;
            end
            for (int p = 0; p < ISSUE_PORT; p++)
                if (grant[p][i]) q_nxt[i].valid = 1'b0;
            if (redirect && !rob_older(q[i].rob_idx, rob_idx_t'(redirect_idx)))
                q_nxt[i].valid = 1'b0;
        end
        // Only slots free at the start of the cycle are allocated; issued slots wait a cycle.
        for (int d = 0; d < DIS_PORT; d++) begin
            if (accept && dis_en[d]) begin
                slot = lowest_one(free);
                for (int i = 0; i < DEPTH; i++) begin
                    if (slot[i]) begin
                        q_nxt[i].valid   = 1'b1;
                        q_nxt[i].rs1     = dis_rs1[d];
                        q_nxt[i].rs2     = dis_rs2[d];
                        q_nxt[i].rs1_rdy = dis_rs1v[d] | woken(dis_rs1[d], wb_en, wb_prd);
                        q_nxt[i].rs2_rdy = dis_rs2v[d] | woken(dis_rs2[d], wb_en, wb_prd);
                        q_nxt[i].rob_idx = rob_idx_t'(dis_robIdx[d]);
                        q_nxt[i].data    = dis_data[d];
                    end
                end
                free = free & ~slot;
            end
        end
        for (int i = 0; i < DEPTH; i++)
            cnt = cnt + CNT_W'(q_nxt[i].valid);
        full_nxt = (cnt > CNT_W'(DEPTH - DIS_PORT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                q[i] <= '0;
            full         <= 1'b0;
            issue_en     <= '0;
            issue_rs1    <= '0;
            issue_rs2    <= '0;
            issue_robIdx <= '0;
            issue_data   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                q[i] <= q_nxt[i];
            full <= full_nxt;
            for (int p = 0; p < ISSUE_PORT; p++) begin
                if (redirect) begin
                    // An unstalled slot was consumed this cycle; a stalled one survives only if older.
                    if (!issue_stall[p] || !rob_older(rob_idx_t'(issue_robIdx[p]), rob_idx_t'(redirect_idx)))
                        issue_en[p] <= 1'b0;
                end else if (!issue_stall[p]) begin
                    issue_en[p]     <= |grant[p];
                    issue_rs1[p]    <= pick_rs1[p];
                    issue_rs2[p]    <= pick_rs2[p];
                    issue_robIdx[p] <= pick_rob[p];
                    issue_data[p]   <= pick_data[p];
                end
            end
        end
    end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer/branch issue queue: the consumer end of the dispatch-to-int-issue interface.
- Accepts up to DIS_PORT micro-ops per cycle from dispatch, together with their busy-table operand status.
- Wakes operands from the writeback bus, selects ready entries and issues up to ISSUE_PORT ops per cycle into registered issue slots feeding register read / integer FUs.
- Flushes wrong-path entries on backend redirect.

Parameters:
- DEPTH, 16, number of entries.
- DIS_PORT, 4, dispatch input ports (equals INT_DISPATCH_PORT).
- ISSUE_PORT, 2, issue output ports.
- WB_PORT, 4, writeback wakeup ports.
- DATA_WIDTH, 64, opaque payload width (integer issue bundle minus rs/robIdx).
- PREG_WIDTH, 7, physical register index width.
- ROB_WIDTH, 6, robIdx width including dir bit (MSB = dir).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- dis_en  in  DIS_PORT  per-port dispatch valid
- dis_rs1, dis_rs2  in  DIS_PORT x PREG_WIDTH  source pregs
- dis_rs1v, dis_rs2v  in  DIS_PORT  1 = operand ready per busy table
- dis_robIdx  in  DIS_PORT x ROB_WIDTH  rob index
- dis_data  in  DIS_PORT x DATA_WIDTH  payload
- full  out  1  queue cannot accept a full dispatch group
- wb_en  in  WB_PORT  writeback valid
- wb_prd  in  WB_PORT x PREG_WIDTH  written preg
- redirect  in  1  backend redirect
- redirect_idx  in  ROB_WIDTH  redirect robIdx
- issue_stall  in  ISSUE_PORT  FU cannot take the issue slot this cycle
- issue_en  out  ISSUE_PORT  issue slot valid
- issue_rs1, issue_rs2  out  ISSUE_PORT x PREG_WIDTH  source pregs
- issue_robIdx  out  ISSUE_PORT x ROB_WIDTH
- issue_data  out  ISSUE_PORT x DATA_WIDTH

Behaviour:
- Reset (rst=0, async):
  - All entry valid bits cleared.
  - issue_en = 0; all issue payload registers = 0.
  - full = 0.
- Entry state: valid, rs1, rs2, rs1_rdy, rs2_rdy, robIdx, data.
- full:
  - Registered; full = 1 when the next-cycle free count < DIS_PORT.
  - Dispatch sends nothing while full = 1. Any dis_en asserted while full = 1 is ignored.
- Allocation:
  - Enabled dispatch ports, in port order, take the lowest-index free slots. Free = not valid at start of cycle.
  - Slots freed this cycle are not reused until the next cycle.
  - All dis_en are ignored in a redirect cycle.
- Wakeup:
  - Any wb_en[k] with wb_prd[k] equal to an entry's rs1/rs2 sets the matching rdy bit at the clock edge.
  - Bypass: the same match on an incoming dispatch op sets its rdy bit on write, so a same-cycle wakeup is not lost.
  - Preg 0 is always ready.
- Select (combinational, from registered state):
  - Ready = valid & rs1_rdy & rs2_rdy.
  - Port p selects the p-th lowest-index ready entry.
  - A port with issue_stall[p] = 1 selects nothing; its slot register holds.
  - Ports whose slot is not stalled but have no candidate load issue_en = 0.
- Issue:
  - Selected entries are invalidated at the edge; the payload is loaded into issue slot p.
  - issue_en is valid the cycle after select: minimum dispatch-to-issue latency is 2 cycles (write, then select).
- Redirect:
  - Keep an entry iff it is strictly older than redirect_idx: (e.dir ^ r.dir) ^ (r.idx > e.idx) = 1.
  - All other entries are invalidated.
  - Issue slots holding younger ops clear issue_en.
  - No select occurs in the redirect cycle.
- Simultaneous events:
  - Issue-free and allocate in the same cycle are independent.
  - Wakeup on an entry being selected is harmless.
  - Redirect overrides dispatch and select.

Optional Feature:
- Macro: INT_ISSUE_AGE_SELECT_EN.
- Defined: port 0 selects the oldest ready entry by robIdx compare (pairwise age matrix among ready entries). Ports 1.. use lowest-index order, excluding the entry picked by port 0.
- Undefined: pure lowest-index selection on all ports; no age logic.

Decomposition:
- Shared package: IssueQueueEntry struct, RobIdx struct {dir, idx}, and the helper function rob_older(a, b) used for redirect compare and age select.
- Sub-module issue_select: ready vector and stall mask in, ISSUE_PORT one-hot grants out, lowest-index cascaded priority encoders. The age variant sits inside it under the macro.

Test Plan:
- Reset then 4 dispatches, all rsXv = 1, robIdx 0..3 -> issue_en = 11 two cycles later with robIdx 0,1, then robIdx 2,3 the next cycle; full stays 0.
- Dispatch op rs1 = 9 not ready; wb_en[0] = 1, wb_prd[0] = 9 in the same cycle -> the op issues 2 cycles later (bypass wakeup).
- Fill to 13 valid entries, none ready -> full = 1. Wake all -> full drops once 4+ entries free.
- Entries robIdx {0,5},{0,6},{0,7},{1,1}; redirect_idx {0,7} -> only robIdx 5 and 6 remain; same-cycle dispatch ignored.
- issue_stall = 01 for 3 cycles with slot 0 valid -> slot 0 data held unchanged; port 1 keeps issuing.
- INT_ISSUE_AGE_SELECT_EN defined: ready entries at slot 0 robIdx {1,2} and slot 3 robIdx {0,30} -> port 0 issues robIdx {0,30}.
